// File: rtl/friscv_pkg.sv
// Shared types and constants for the core's memory-side blocks.
package friscv_pkg;

  // Memory port arbiter: idle, or waiting on the response for the I or D owner.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT_I = 2'd1,
    ARB_WAIT_D = 2'd2
  } arb_state_t;

  // Values of the arbiter's select line for the memory-side muxes.
  localparam logic ARB_SEL_INSTR = 1'b0;
  localparam logic ARB_SEL_DATA  = 1'b1;

endpackage

// File: rtl/mux_2_way.sv
// Generic two-input mux; sel_in = 0 picks a_in, sel_in = 1 picks b_in.
module mux_2_way #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sel_in,
  output logic [WIDTH-1:0] y_out
);

  // Plain select.
  always_comb begin
    y_out = sel_in ? b_in : a_in;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch (I) and load/store (D)
// requesters. One transaction outstanding at a time; the response is routed
// back to its owner, D-side starvation of fetch is bounded by a streak
// counter, and a silent memory is recovered from by a wait timeout.
module mem_port_arbiter
  import friscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Fetch requester
  input  logic                    i_req_in,
  input  logic [ADDR_WIDTH-1:0]   i_addr_in,
  output logic                    i_gnt_out,
  output logic                    i_rvalid_out,
  output logic [DATA_WIDTH-1:0]   i_rdata_out,
  // Load/store requester
  input  logic                    d_req_in,
  input  logic                    d_we_in,
  input  logic [ADDR_WIDTH-1:0]   d_addr_in,
  input  logic [DATA_WIDTH-1:0]   d_wdata_in,
  input  logic [DATA_WIDTH/8-1:0] d_be_in,
  output logic                    d_gnt_out,
  output logic                    d_rvalid_out,
  output logic [DATA_WIDTH-1:0]   d_rdata_out,
  // Memory side
  output logic                    mem_req_out,
  output logic                    mem_we_out,
  output logic [DATA_WIDTH/8-1:0] mem_be_out,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_wdata_out,
  input  logic                    mem_rvalid_in,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_in,
  // Status
  output logic                    sel_out,
  output logic                    err_out
);

  localparam int unsigned WaitW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned StreakW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;

  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);
  // Abort fires in the wait cycle where the counter would reach TIMEOUT_CYCLES.
  localparam logic [WaitW-1:0]   WaitLast  = WaitW'(TIMEOUT_CYCLES - 1);

  arb_state_t          state_q, state_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [StreakW-1:0]  streak_q, streak_d;

  logic                win_i;
  logic                win_d;
  logic                timeout;
  logic [ADDR_WIDTH-1:0] mux_addr;
  logic [DATA_WIDTH-1:0] mux_wdata;

  // Winner selection; only meaningful in ARB_IDLE.
  always_comb begin
    win_i = 1'b0;
    win_d = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (d_req_in && !(i_req_in && (streak_q == StreakMax))) begin
        win_d = 1'b1;
      end else if (i_req_in) begin
        win_i = 1'b1;
      end
    end
  end

  // A response in the expiry cycle takes priority over the abort.
  assign timeout = (state_q != ARB_IDLE) && !mem_rvalid_in && (wait_q == WaitLast);

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      wait_q   <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      streak_q <= streak_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_d) begin
          state_d = ARB_WAIT_D;
        end else if (win_i) begin
          state_d = ARB_WAIT_I;
        end
      end
      ARB_WAIT_I, ARB_WAIT_D: begin
        if (mem_rvalid_in || timeout) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Wait and streak counters.
  always_comb begin
    wait_d   = wait_q;
    streak_d = streak_q;
    if (state_q == ARB_IDLE || mem_rvalid_in || timeout) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + 1'b1;
    end
    if (win_i) begin
      streak_d = '0;
    end else if (win_d) begin
      if (!i_req_in) begin
        streak_d = '0;
      end else if (streak_q != StreakMax) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  // Outputs; everything is forced low while reset is asserted.
  always_comb begin
    i_gnt_out    = 1'b0;
    i_rvalid_out = 1'b0;
    i_rdata_out  = '0;
    d_gnt_out    = 1'b0;
    d_rvalid_out = 1'b0;
    d_rdata_out  = '0;
    mem_req_out  = 1'b0;
    mem_we_out   = 1'b0;
    mem_be_out   = '0;
    sel_out      = ARB_SEL_INSTR;
    err_out      = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ARB_IDLE: begin
          i_gnt_out   = win_i;
          d_gnt_out   = win_d;
          mem_req_out = win_i | win_d;
          sel_out     = win_d ? ARB_SEL_DATA : ARB_SEL_INSTR;
          mem_we_out  = win_d & d_we_in;
          mem_be_out  = win_d ? d_be_in : '0;
        end
        ARB_WAIT_I: begin
          sel_out = ARB_SEL_INSTR;
          if (mem_rvalid_in) begin
            i_rvalid_out = 1'b1;
            i_rdata_out  = mem_rdata_in;
          end else if (timeout) begin
            i_rvalid_out = 1'b1;
            err_out      = 1'b1;
          end
        end
        ARB_WAIT_D: begin
          sel_out = ARB_SEL_DATA;
          if (mem_rvalid_in) begin
            d_rvalid_out = 1'b1;
            d_rdata_out  = mem_rdata_in;
          end else if (timeout) begin
            d_rvalid_out = 1'b1;
            err_out      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  mux_2_way #(
    .WIDTH (ADDR_WIDTH)
  ) u_addr_mux (
    .a_in   (i_addr_in),
    .b_in   (d_addr_in),
    .sel_in (sel_out),
    .y_out  (mux_addr)
  );

  mux_2_way #(
    .WIDTH (DATA_WIDTH)
  ) u_wdata_mux (
    .a_in   ('0),
    .b_in   (d_wdata_in),
    .sel_in (sel_out),
    .y_out  (mux_wdata)
  );

  // Address and write data are only driven alongside a request.
  assign mem_addr_out  = mem_req_out ? mux_addr : '0;
  assign mem_wdata_out = mem_req_out ? mux_wdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared single-port memory between the instruction-fetch requester (I) and the load/store requester (D) of the pipelined core. It owns the select line of the address/write-data `mux_2_way` instances in front of the memory. It tracks the single outstanding transaction and routes the response back to its owner. It also bounds D-side starvation of fetch and recovers from unresponsive memory via a timeout.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width; byte-enable width is `DATA_WIDTH/8`.
- `MAX_D_STREAK`, default 4: maximum consecutive D grants while I is waiting.
- `TIMEOUT_CYCLES`, default 16: cycles in a wait state before abort; must be at least 1.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: **one clock; reset is asynchronous and active-low**.
- `i_req_in` in 1: fetch request; held until `i_gnt_out`.
- `i_addr_in` in ADDR_WIDTH: fetch address.
- `i_gnt_out` out 1: fetch request accepted this cycle.
- `i_rvalid_out` out 1: fetch response pulse.
- `i_rdata_out` out DATA_WIDTH: fetch data, valid with `i_rvalid_out`.
- `d_req_in` in 1: load/store request; held until `d_gnt_out`.
- `d_we_in` in 1: 1 means store.
- `d_addr_in` in ADDR_WIDTH: data address.
- `d_wdata_in` in DATA_WIDTH: store data.
- `d_be_in` in DATA_WIDTH/8: byte enables.
- `d_gnt_out` out 1: data request accepted.
- `d_rvalid_out` out 1: data response pulse; this is the ack for stores.
- `d_rdata_out` out DATA_WIDTH: load data.
- `mem_req_out` out 1: single-cycle request to memory.
- `mem_we_out` out 1: write strobe.
- `mem_be_out` out DATA_WIDTH/8: byte enables.
- `mem_addr_out` out ADDR_WIDTH: muxed address.
- `mem_wdata_out` out DATA_WIDTH: write data.
- `mem_rvalid_in` in 1: memory response.
- `mem_rdata_in` in DATA_WIDTH: memory read data.
- `sel_out` out 1: current owner; 0 means I, 1 means D.
- `err_out` out 1: timeout abort pulse.

## Operation
- The FSM has three states: `ARB_IDLE`, `ARB_WAIT_I` and `ARB_WAIT_D`.
- **ARB_IDLE, winner selection:**
  - If only one requester asks, it wins.
  - If both ask, D wins, unless `streak == MAX_D_STREAK`; then I wins.
- **ARB_IDLE, grant:** in the same cycle, the arbiter combinationally asserts the winner's `gnt`, `mem_req_out` and `sel_out = winner`, then moves to `ARB_WAIT_I` or `ARB_WAIT_D`.
- **Write-side outputs:** `mem_we_out` and `mem_be_out` are valid only for a D grant; they are 0 otherwise.
- **Streak counter:**
  - Cleared on every I grant.
  - Cleared on a D grant when `i_req_in = 0`.
  - Incremented on a D grant when `i_req_in = 1`.
  - Saturates at `MAX_D_STREAK`.
- **ARB_WAIT_x:**
  - `sel_out` holds the owner.
  - On `mem_rvalid_in`, the owner's `rvalid` pulses the same cycle, with `rdata = mem_rdata_in`, and the FSM returns to `ARB_IDLE`.
  - No new grant is issued in a wait state.
- **Timeout:**
  - The wait counter clears on entry to a wait state and increments each wait cycle without `mem_rvalid_in`.
  - When it reaches `TIMEOUT_CYCLES`, the owner's `rvalid` pulses with `rdata = 0`, `err_out` pulses, and the FSM returns to `ARB_IDLE`.
  - A late `mem_rvalid_in` that arrives in `ARB_IDLE` is ignored and not forwarded.
- **Width:** the wait counter is `$clog2(TIMEOUT_CYCLES+1)` bits.
- **Non-owner outputs:** the non-owner's `rdata` output is driven 0.

## Timing
- **Reset values:** state `ARB_IDLE`, both counters 0, and every output 0 (all gnt, rvalid, rdata, mem_* and `err_out` signals, plus `sel_out`).
- **Reset mid-transaction:** returns to `ARB_IDLE`; the response that arrives afterwards is dropped.
- **Minimum latency:** grant at cycle T, response at T+1 at the earliest, next grant at T+2. Sustained throughput is one transaction per two cycles.
- **Requester rule:** a requester must keep `req`/`addr`/`wdata` stable until its `gnt`.
- **Grant pulse:** `gnt` is a one-cycle pulse.
- **Simultaneous events:** when `mem_rvalid_in` and timeout expiry coincide, the response wins and `err_out` stays 0.

## Structure
- `friscv_pkg` gains:
  - `arb_state_t`, an enum of `ARB_IDLE`, `ARB_WAIT_I`, `ARB_WAIT_D`.
  - Constants `ARB_SEL_INSTR = 1'b0` and `ARB_SEL_DATA = 1'b1`.
- Sub-modules: two `mux_2_way` instances driven by `sel_out`.
  - Address path: `a_in = i_addr_in`, `b_in = d_addr_in`.
  - Write-data path: `a_in = 0`, `b_in = d_wdata_in`.
- The FSM and counters live in this module.

## Test plan
- **Single fetch:** `i_req_in` with `i_addr_in = 0x100`, memory answers at T+1 with `0xDEADBEEF` -> `i_gnt_out`, `mem_addr_out = 0x100` and `sel_out = 0` at T; `i_rvalid_out` with `i_rdata_out = 0xDEADBEEF` at T+1.
- **Store:** `d_we_in = 1`, `d_addr_in = 0x200`, `d_wdata_in = 0x12345678`, `d_be_in = 0xF` -> `mem_we_out = 1` with these values and `sel_out = 1`; `d_rvalid_out` pulses on the ack.
- **Contention:** both request continuously with `MAX_D_STREAK = 4` -> grant sequence D, D, D, D, I, D, D, D, D, I.
- **Timeout:** D granted, memory silent, `TIMEOUT_CYCLES = 16` -> `d_rvalid_out`, `err_out` and `d_rdata_out = 0` at grant+16; a late `mem_rvalid_in` at grant+20 is ignored.
- **Coincident response and timeout:** `mem_rvalid_in` at exactly grant+16 -> normal response and `err_out = 0`.
- **Reset mid-transaction:** `rst_n` low during `ARB_WAIT_I` -> all outputs 0 immediately; the subsequent `mem_rvalid_in` does not raise `i_rvalid_out`.
